cr16_control: RTL and testbench

Multi-cycle instruction sequencer feeding the `alu` stage. Owns the PC and instruction register and decodes each 16-bit instruction into `aluControl`, operand selects and register-file and memory strobes. It consumes the registered ALU flags (C, L, F, Z, N) to resolve conditional branches and jumps. Sits between unified instruction/data memory and the register-file/ALU datapath.

---
 rtl/cr16_control.sv | 188 ++++++++++++++++++
 tb/tb_cr16_control.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_control.sv
// cr16_control: multi-cycle FETCH/DECODE/EXEC(/MEM) sequencer for the CR16 datapath.
// Owns PC and IR; every output is decoded from the state register and IR only,
// except the write strobes, which are additionally suppressed while reset is high
// so an aborted instruction never writes anything.
module cr16_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] rtarget,
    input  logic        Cin,
    input  logic        Lin,
    input  logic        Fin,
    input  logic        Zin,
    input  logic        Nin,
    output logic [15:0] pc,
    output logic        mem_addr_sel,
    output logic        mem_we,
    output logic [3:0]  aluControl,
    output logic [3:0]  rdest,
    output logic [3:0]  rsrc,
    output logic [15:0] imm,
    output logic        imm_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_MEM    = 2'd3;

    localparam logic [3:0] CODE_CMP = 4'b1011;
    localparam logic [3:0] CODE_MOV = 4'b1101;
    localparam logic [3:0] CODE_LUI = 4'b1111;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    // Maps an ALU function code (register ext or immediate opcode) to aluControl; bit 4 = valid.
    function automatic logic [4:0] alu_lookup(input logic [3:0] code);
        case (code)
            4'b0101: alu_lookup = {1'b1, 4'b1000};   // ADD
            4'b1001: alu_lookup = {1'b1, 4'b0001};   // SUB
            4'b1011: alu_lookup = {1'b1, 4'b0010};   // CMP
            4'b0001: alu_lookup = {1'b1, 4'b0011};   // AND
            4'b0010: alu_lookup = {1'b1, 4'b0100};   // OR
            4'b0011: alu_lookup = {1'b1, 4'b0101};   // XOR
            4'b1101: alu_lookup = {1'b1, 4'b0000};   // MOV
            default: alu_lookup = 5'b0_0000;
        endcase
    endfunction

    logic [3:0]  op, ext;
    logic [4:0]  ext_alu, op_alu;
    logic [15:0] imm_sx, imm_zx;

    assign op      = ir_q[15:12];
    assign ext     = ir_q[7:4];
    assign ext_alu = alu_lookup(ext);
    assign op_alu  = alu_lookup(op);
    assign imm_sx  = {{8{ir_q[7]}}, ir_q[7:0]};
    assign imm_zx  = {8'h00, ir_q[7:0]};

    // Condition codes come in complementary pairs: even code = base term, odd code = its inverse.
    logic [7:0]  cond_base;
    logic [15:0] cond_vec;
    logic        cond_true;

    assign cond_base = {1'b1, ~Nin & ~Zin, ~Lin & ~Zin, Fin, Nin, Lin, Cin, Zin};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cond
            assign cond_vec[2*gi]   = cond_base[gi];
            assign cond_vec[2*gi+1] = ~cond_base[gi];
        end
    endgenerate

    assign cond_true = cond_vec[ir_q[11:8]];

    logic [3:0] dec_alu;
    logic       dec_rwe, dec_isel, dec_zext;
    logic [1:0] dec_wb;
    logic       dec_load, dec_stor, dec_jal, dec_jcond, dec_bcond;

    // Instruction decode from IR alone.
    always_comb begin
        dec_alu   = 4'b0000;
        dec_rwe   = 1'b0;
        dec_isel  = 1'b0;
        dec_zext  = 1'b0;
        dec_wb    = 2'b00;
        dec_load  = 1'b0;
        dec_stor  = 1'b0;
        dec_jal   = 1'b0;
        dec_jcond = 1'b0;
        dec_bcond = 1'b0;
        if (op == 4'b0000) begin
            if (ext_alu[4]) begin
                dec_alu = ext_alu[3:0];
                dec_rwe = (ext != CODE_CMP);
                dec_wb  = (ext == CODE_MOV) ? 2'b10 : 2'b00;
            end
        end else if (op == 4'b1000) begin
            if (ext == 4'b0100) begin
                dec_alu = 4'b0111;
                dec_rwe = 1'b1;
            end
        end else if (op_alu[4] || op == CODE_LUI) begin
            dec_isel = 1'b1;
            dec_alu  = (op == CODE_LUI) ? 4'b0110 : op_alu[3:0];
            dec_rwe  = (op != CODE_CMP);
            dec_wb   = (op == CODE_MOV) ? 2'b10 : 2'b00;
            dec_zext = (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011) || (op == CODE_LUI);
        end else if (op == 4'b0100) begin
            case (ext)
                4'b0000: begin dec_load = 1'b1; dec_wb = 2'b01; end
                4'b0100: dec_stor = 1'b1;
                4'b1000: begin dec_jal = 1'b1; dec_rwe = 1'b1; dec_wb = 2'b11; end
                4'b1100: dec_jcond = 1'b1;
                default: ;
            endcase
        end else if (op == 4'b1100) begin
            dec_bcond = 1'b1;
        end
    end

    logic in_exec, in_mem;
    assign in_exec = (state_q == S_EXEC);
    assign in_mem  = (state_q == S_MEM);

    assign pc           = pc_q;
    assign rdest        = ir_q[11:8];
    assign rsrc         = ir_q[3:0];
    assign imm          = dec_zext ? imm_zx : imm_sx;
    assign imm_sel      = dec_isel;
    assign wb_sel       = dec_wb;
    assign aluControl   = in_exec ? dec_alu : 4'b0000;
    assign mem_addr_sel = (in_exec & (dec_load | dec_stor)) | in_mem;
    assign reg_we       = ~reset & ((in_exec & dec_rwe) | in_mem);
    assign mem_we       = ~reset & in_exec & dec_stor;

    // Next-state, IR capture and PC update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = dec_load ? S_MEM : S_FETCH;
                if (dec_load)
                    pc_d = pc_q;
                else if (dec_jal || (dec_jcond && cond_true))
                    pc_d = rtarget;
                else if (dec_bcond && cond_true)
                    pc_d = pc_q + imm_sx;
                else
                    pc_d = pc_q + 16'd1;
            end
            default: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 16'd1;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_cr16_control.sv
// tb_cr16_control: instruction-level reference model driven with directed and random
// instructions; a negedge compare process checks every output field on every cycle.
module tb_cr16_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata, rtarget;
    logic        Cin, Lin, Fin, Zin, Nin;
    logic [15:0] pc, imm;
    logic        mem_addr_sel, mem_we, imm_sel, reg_we;
    logic [3:0]  aluControl, rdest, rsrc;
    logic [1:0]  wb_sel;

    always #5 clk = ~clk;

    cr16_control dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .rtarget(rtarget),
        .Cin(Cin), .Lin(Lin), .Fin(Fin), .Zin(Zin), .Nin(Nin),
        .pc(pc), .mem_addr_sel(mem_addr_sel), .mem_we(mem_we), .aluControl(aluControl),
        .rdest(rdest), .rsrc(rsrc), .imm(imm), .imm_sel(imm_sel), .reg_we(reg_we),
        .wb_sel(wb_sel)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  alu;
        logic        rwe;
        logic [1:0]  wb;
        logic        isel;
        logic        imm_chk;
        logic [15:0] imm;
        logic        mas;
        logic        mwe;
        logic        load;
        logic [15:0] npc;
    } exec_t;

    // expected outputs for the current cycle
    logic [15:0] e_pc, e_imm;
    logic        e_mas, e_mwe, e_rwe, e_isel;
    logic [3:0]  e_alu, e_rdest, e_rsrc;
    logic [1:0]  e_wb;
    bit          chk_en = 0, dec_chk = 0, imm_chk = 0;

    logic [15:0] m_pc = 16'h0000;
    int          mwe_cnt = 0;
    logic [3:0]  x_alu;
    logic [15:0] x_imm;
    logic        x_rwe, x_mem_rwe, x_mem_mas;
    logic [1:0]  x_wb, x_mem_wb;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, e_pc);
            chk("mem_addr_sel", 16'(mem_addr_sel), 16'(e_mas));
            chk("mem_we", 16'(mem_we), 16'(e_mwe));
            chk("reg_we", 16'(reg_we), 16'(e_rwe));
            chk("aluControl", 16'(aluControl), 16'(e_alu));
            if (e_rwe) chk("wb_sel", 16'(wb_sel), 16'(e_wb));
            if (dec_chk) begin
                chk("imm_sel", 16'(imm_sel), 16'(e_isel));
                chk("rdest", 16'(rdest), 16'(e_rdest));
                chk("rsrc", 16'(rsrc), 16'(e_rsrc));
            end
            if (imm_chk) chk("imm", imm, e_imm);
        end
    end

    function automatic logic cond_holds(input logic [3:0] c, input logic [4:0] f);
        logic C, L, F, Z, N;
        {C, L, F, Z, N} = f;
        case (c)
            4'd0:  return Z;
            4'd1:  return !Z;
            4'd2:  return C;
            4'd3:  return !C;
            4'd4:  return L;
            4'd5:  return !L;
            4'd6:  return N;
            4'd7:  return !N;
            4'd8:  return F;
            4'd9:  return !F;
            4'd10: return !L && !Z;
            4'd11: return L || Z;
            4'd12: return !N && !Z;
            4'd13: return N || Z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int alu_for(input logic [3:0] code);
        case (code)
            4'd5:  return 8;
            4'd9:  return 1;
            4'd11: return 2;
            4'd1:  return 3;
            4'd2:  return 4;
            4'd3:  return 5;
            4'd13: return 0;
            default: return -1;
        endcase
    endfunction

    function automatic exec_t model(input logic [15:0] ins, input logic [15:0] cur_pc,
                                    input logic [4:0] f, input logic [15:0] rt);
        exec_t r;
        logic [3:0] op, ext;
        logic [15:0] sx, zx;
        op = ins[15:12];
        ext = ins[7:4];
        sx = {{8{ins[7]}}, ins[7:0]};
        zx = {8'h00, ins[7:0]};
        r.alu = 4'd0; r.rwe = 0; r.wb = 2'd0; r.isel = 0; r.imm_chk = 0; r.imm = 16'd0;
        r.mas = 0; r.mwe = 0; r.load = 0; r.npc = cur_pc + 16'd1;
        if (op == 4'd0 && alu_for(ext) >= 0) begin
            r.alu = 4'(alu_for(ext));
            r.rwe = (ext != 4'd11);
            r.wb  = (ext == 4'd13) ? 2'd2 : 2'd0;
        end else if (op == 4'd8 && ext == 4'd4) begin
            r.alu = 4'd7;
            r.rwe = 1;
        end else if (alu_for(op) >= 0 || op == 4'd15) begin
            r.isel = 1;
            r.imm_chk = 1;
            r.alu = (op == 4'd15) ? 4'd6 : 4'(alu_for(op));
            r.rwe = (op != 4'd11);
            r.wb  = (op == 4'd13) ? 2'd2 : 2'd0;
            r.imm = (op == 4'd5 || op == 4'd9 || op == 4'd11 || op == 4'd13) ? sx : zx;
        end else if (op == 4'd4 && ext == 4'd0) begin
            r.mas = 1;
            r.load = 1;
        end else if (op == 4'd4 && ext == 4'd4) begin
            r.mas = 1;
            r.mwe = 1;
        end else if (op == 4'd4 && ext == 4'd8) begin
            r.rwe = 1;
            r.wb = 2'd3;
            r.npc = rt;
        end else if (op == 4'd4 && ext == 4'd12) begin
            if (cond_holds(ins[11:8], f)) r.npc = rt;
        end else if (op == 4'd12) begin
            if (cond_holds(ins[11:8], f)) r.npc = cur_pc + sx;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        {Cin, Lin, Fin, Zin, Nin} = 5'($urandom);
        rtarget   = 16'($urandom);
        mem_rdata = 16'($urandom);
    endtask

    task automatic set_idle(input logic [15:0] p);
        e_pc = p; e_mas = 0; e_mwe = 0; e_rwe = 0; e_alu = 4'd0; e_wb = 2'd0;
        e_isel = 0; e_imm = 16'd0; dec_chk = 0; imm_chk = 0;
    endtask

    task automatic set_exec(input exec_t r, input logic [15:0] ins);
        e_pc = m_pc; e_mas = r.mas; e_mwe = r.mwe; e_rwe = r.rwe; e_alu = r.alu;
        e_wb = r.wb; e_isel = r.isel; e_imm = r.imm; imm_chk = r.imm_chk;
        e_rdest = ins[11:8]; e_rsrc = ins[3:0]; dec_chk = 1;
    endtask

    task automatic end_cycle();
        #1;
        mwe_cnt += int'(mem_we);
        tick();
    endtask

    // Runs one instruction starting in the cycle where the DUT sits in FETCH.
    task automatic run_instr(input logic [15:0] ins, input bit ff, input logic [4:0] fv,
                             input bit fr, input logic [15:0] rv);
        exec_t r;
        logic [4:0] f;
        logic [15:0] rt;
        logic [15:0] start_pc;
        start_pc = m_pc;
        rand_in(); set_idle(m_pc); end_cycle();
        rand_in(); mem_rdata = ins; set_idle(m_pc); end_cycle();
        rand_in();
        f  = ff ? fv : 5'($urandom);
        rt = fr ? rv : 16'($urandom);
        {Cin, Lin, Fin, Zin, Nin} = f;
        rtarget = rt;
        r = model(ins, m_pc, f, rt);
        set_exec(r, ins);
        #1;
        x_alu = aluControl; x_imm = imm; x_rwe = reg_we; x_wb = wb_sel;
        end_cycle();
        if (r.load) begin
            rand_in(); set_idle(m_pc); e_mas = 1; e_rwe = 1; e_wb = 2'b01;
            #1;
            x_mem_wb = wb_sel; x_mem_rwe = reg_we; x_mem_mas = mem_addr_sel;
            end_cycle();
        end
        m_pc = r.npc;
        $display("instr %h flags %b rt %h pc %h -> %h", ins, f, rt, start_pc, m_pc);
    endtask

    function automatic logic [15:0] gen_instr();
        logic [3:0] alu_codes [8];
        logic [15:0] w;
        alu_codes = '{4'd5, 4'd9, 4'd11, 4'd1, 4'd2, 4'd3, 4'd13, 4'd15};
        w = 16'($urandom);
        case ($urandom_range(0, 9))
            0: w = {4'd0, w[11:8], alu_codes[$urandom_range(0, 6)], w[3:0]};
            1: w = {4'd8, w[11:8], 4'd4, w[3:0]};
            2: w = {alu_codes[$urandom_range(0, 7)], w[11:0]};
            3: w = {4'd4, w[11:8], 4'd0, w[3:0]};
            4: w = {4'd4, w[11:8], 4'd4, w[3:0]};
            5: w = {4'd4, w[11:8], 4'd12, w[3:0]};
            6: w = {4'd4, w[11:8], 4'd8, w[3:0]};
            7, 8: w = {4'd12, w[11:0]};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        exec_t r;
        int m0;
        reset = 1'b1;
        mem_rdata = 16'h0; rtarget = 16'h0;
        {Cin, Lin, Fin, Zin, Nin} = 5'b0;
        tick(); tick();
        set_idle(16'h0000);
        chk_en = 1;
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_alu", 16'(aluControl), 16'h0000);
        chk("rst_reg_we", 16'(reg_we), 16'h0000);
        chk("rst_mem_we", 16'(mem_we), 16'h0000);
        chk("rst_rdest", 16'(rdest), 16'h0000);
        reset = 1'b0;
        $display("reset released pc %h", pc);

        run_instr(16'h5AFF, 0, 5'd0, 0, 16'd0);
        chk("addi_alu", 16'(x_alu), 16'h0008);
        chk("addi_imm", x_imm, 16'hFFFF);
        chk("addi_reg_we", 16'(x_rwe), 16'h0001);
        chk("addi_pc", pc, 16'h0001);
        run_instr(16'h01B2, 0, 5'd0, 0, 16'd0);
        chk("cmp_reg_we", 16'(x_rwe), 16'h0000);
        run_instr(16'hC004, 1, 5'b00010, 0, 16'd0);
        chk("beq_taken_pc", pc, 16'h0006);
        run_instr(16'h01B2, 0, 5'd0, 0, 16'd0);
        run_instr(16'hC004, 1, 5'b11101, 0, 16'd0);
        chk("beq_not_taken_pc", pc, 16'h0008);
        run_instr(16'h4302, 0, 5'd0, 0, 16'd0);
        chk("load_wb_sel", 16'(x_mem_wb), 16'h0001);
        chk("load_reg_we", 16'(x_mem_rwe), 16'h0001);
        chk("load_addr_sel", 16'(x_mem_mas), 16'h0001);
        chk("load_pc", pc, 16'h0009);
        m0 = mwe_cnt;
        run_instr(16'h4342, 0, 5'd0, 0, 16'd0);
        chk("stor_we_cycles", 16'(mwe_cnt - m0), 16'h0001);
        run_instr(16'h4EC0, 1, 5'd0, 1, 16'h0010);
        chk("juc_pc", pc, 16'h0010);
        run_instr(16'h4184, 0, 5'd0, 1, 16'h1234);
        chk("jal_wb_sel", 16'(x_wb), 16'h0003);
        chk("jal_reg_we", 16'(x_rwe), 16'h0001);
        chk("jal_pc", pc, 16'h1234);

        // ADD aborted by a two-cycle reset asserted during its EXEC
        rand_in(); set_idle(m_pc); end_cycle();
        rand_in(); mem_rdata = 16'h0A53; set_idle(m_pc); end_cycle();
        rand_in(); reset = 1'b1;
        r = model(16'h0A53, m_pc, 5'd0, 16'd0);
        set_exec(r, 16'h0A53); e_rwe = 0; e_mwe = 0;
        #1; x_rwe = reg_we; end_cycle();
        chk("abort_exec_reg_we", 16'(x_rwe), 16'h0000);
        rand_in(); set_idle(16'h0000);
        #1; x_rwe = reg_we; end_cycle();
        chk("abort_fetch_reg_we", 16'(x_rwe), 16'h0000);
        reset = 1'b0;
        m_pc = 16'h0000;
        chk("abort_pc", pc, 16'h0000);
        $display("reset abort of ADD, pc %h", pc);

        run_instr(16'h4EC0, 1, 5'd0, 1, 16'h0001);
        run_instr(16'hCEFE, 0, 5'd0, 0, 16'd0);
        chk("buc_wrap_pc", pc, 16'hFFFF);
        run_instr(16'h0000, 0, 5'd0, 0, 16'd0);
        chk("nop_wrap_pc", pc, 16'h0000);

        for (int i = 0; i < 300; i++) run_instr(gen_instr(), 0, 5'd0, 0, 16'd0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
